// File: rtl/serial_pkg.sv
// Shared serial-link types and line levels, imported by the transmitter and the future receiver.
package serial_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Free-running bit-period counter; tick marks the last cycle of each CLKS_PER_BIT period.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, WIDTH data bits LSB first, one stop bit, idle-high line.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             q,
    output logic             busy
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] shift_reg, shift_n;
    logic [IW-1:0]    bit_idx, idx_n;
    logic             q_n, busy_n;
    logic             tick;

    // Timer is held in reset while idle so every frame starts on a fresh bit period.
    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .tick (tick)
    );

    assign d_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            q         <= IDLE_LVL;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            bit_idx   <= idx_n;
            q         <= q_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        idx_n   = bit_idx;
        q_n     = IDLE_LVL;
        busy_n  = 1'b0;

        case (state)
            IDLE: begin
                if (d_valid) begin
                    state_n = START;
                    shift_n = d;
                    idx_n   = '0;
                end
            end
            START: begin
                if (tick) state_n = DATA;
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_IDX) begin
                        state_n = STOP;
                    end else begin
                        shift_n = shift_reg >> 1;
                        idx_n   = bit_idx + IW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Line level is registered from the upcoming state so q changes one cycle after acceptance.
        case (state_n)
            IDLE:    q_n = IDLE_LVL;
            START:   q_n = START_LVL;
            DATA:    q_n = shift_n[0];
            STOP:    q_n = STOP_LVL;
            default: q_n = IDLE_LVL;
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: expected line levels queued at acceptance, popped every cycle.
module tb_serial_tx;

    localparam int unsigned C  = 4;
    localparam int unsigned FL = 10 * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d = '0;
    logic       d_valid = 1'b0;
    logic       d_ready, q, busy;
    logic [0:0] d1 = '0;
    logic       dv1 = 1'b0;
    logic       rdy1, q1, busy1;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    logic exp_q[$];
    logic e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid),
        .d_ready(d_ready), .q(q), .busy(busy)
    );

    serial_tx #(.WIDTH(1), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .d(d1), .d_valid(dv1),
        .d_ready(rdy1), .q(q1), .busy(busy1)
    );

    task automatic push_frame8(input logic [7:0] v);
        for (int j = 0; j < int'(C); j++) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < int'(C); j++) exp_q.push_back(v[i]);
        for (int j = 0; j < int'(C); j++) exp_q.push_back(1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        d_valid = 1'b1;
        d = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (q !== 1'b1 || busy !== 1'b0 || d_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold k=%0d q=%b busy=%b rdy=%b expected q=1 busy=0 rdy=0", k, q, busy, d_ready);
            end
        end
        rst = 1'b0;
        d_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (q !== 1'b1 || busy !== 1'b0 || d_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_release k=%0d q=%b busy=%b rdy=%b expected q=1 busy=0 rdy=1", k, q, busy, d_ready);
            end
        end
    endtask

    task automatic test_single(input logic [7:0] v, input string name);
        checks++;
        if (d_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready rdy=%b expected 1", name, d_ready);
        end
        d = v;
        d_valid = 1'b1;
        push_frame8(v);
        for (int k = 0; k < int'(FL); k++) begin
            @(negedge clk);
            d_valid = 1'b0;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            checks++;
            if (q !== e || busy !== 1'b1 || d_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s k=%0d q=%b busy=%b rdy=%b expected q=%b busy=1 rdy=0", name, k, q, busy, d_ready, e);
            end
        end
        @(negedge clk);
        checks++;
        if (q !== 1'b1 || busy !== 1'b0 || d_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_end q=%b busy=%b rdy=%b expected q=1 busy=0 rdy=1", name, q, busy, d_ready);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned t_a, t_b;
        d = 8'h00;
        d_valid = 1'b1;
        t_a = cyc;
        push_frame8(8'h00);
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < int'(FL); k++) begin
                @(negedge clk);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                checks++;
                if (q !== e || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b f=%0d k=%0d q=%b busy=%b expected q=%b busy=1", f, k, q, busy, e);
                end
                if (f == 0 && k == int'(FL) - 1) d = 8'hFF;
            end
            @(negedge clk);
            checks++;
            if (q !== 1'b1 || busy !== 1'b0 || d_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_gap f=%0d q=%b busy=%b rdy=%b expected q=1 busy=0 rdy=1", f, q, busy, d_ready);
            end
            if (f == 0) begin
                t_b = cyc;
                push_frame8(8'hFF);
                checks++;
                if (t_b - t_a !== FL + 1) begin
                    errors++;
                    $display("FAIL b2b_period got=%0d expected %0d", t_b - t_a, FL + 1);
                end
            end else begin
                d_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || q !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stop busy=%b q=%b expected busy=0 q=1", busy, q);
        end
    endtask

    task automatic test_data_change();
        d = 8'h3C;
        d_valid = 1'b1;
        push_frame8(8'h3C);
        for (int k = 0; k < int'(FL); k++) begin
            @(negedge clk);
            if (k == 0) d_valid = 1'b0;
            if (k == int'(2 * C)) begin
                d = 8'hFF;
                d_valid = 1'b1;
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            checks++;
            if (q !== e || busy !== 1'b1 || d_ready !== 1'b0) begin
                errors++;
                $display("FAIL change k=%0d q=%b busy=%b rdy=%b expected q=%b busy=1 rdy=0", k, q, busy, d_ready, e);
            end
            if (k == int'(FL) - 1) d_valid = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (q !== 1'b1 || busy !== 1'b0 || d_ready !== 1'b1) begin
                errors++;
                $display("FAIL change_idle k=%0d q=%b busy=%b rdy=%b expected q=1 busy=0 rdy=1", k, q, busy, d_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        d = 8'hC3;
        d_valid = 1'b1;
        push_frame8(8'hC3);
        // Stop inside data bit 3 (cycles t0+17..t0+20 for C=4).
        for (int k = 0; k < int'(4 * C + 2); k++) begin
            @(negedge clk);
            d_valid = 1'b0;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            checks++;
            if (q !== e || busy !== 1'b1) begin
                errors++;
                $display("FAIL midrst_pre k=%0d q=%b busy=%b expected q=%b busy=1", k, q, busy, e);
            end
        end
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (q !== 1'b1 || busy !== 1'b0 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort q=%b busy=%b rdy=%b expected q=1 busy=0 rdy=0", q, busy, d_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (q !== 1'b1 || busy !== 1'b0 || d_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_idle q=%b busy=%b rdy=%b expected q=1 busy=0 rdy=1", q, busy, d_ready);
        end
        test_single(8'h5A, "after_rst");
    endtask

    task automatic test_corner();
        logic exp1[$];
        checks++;
        if (rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL corner_ready rdy=%b expected 1", rdy1);
        end
        d1 = 1'b1;
        dv1 = 1'b1;
        exp1.push_back(1'b0);
        exp1.push_back(1'b1);
        exp1.push_back(1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dv1 = 1'b0;
            e = exp1.pop_front();
            checks++;
            if (q1 !== e || busy1 !== 1'b1 || rdy1 !== 1'b0) begin
                errors++;
                $display("FAIL corner k=%0d q=%b busy=%b rdy=%b expected q=%b busy=1 rdy=0", k, q1, busy1, rdy1, e);
            end
        end
        @(negedge clk);
        checks++;
        if (q1 !== 1'b1 || busy1 !== 1'b0 || rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL corner_end q=%b busy=%b rdy=%b expected q=1 busy=0 rdy=1", q1, busy1, rdy1);
        end
    endtask

    initial begin
        test_reset();
        test_single(8'hA5, "single");
        test_back_to_back();
        test_data_change();
        test_reset_mid();
        test_corner();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d expected completion", cyc);
        $fatal(1);
    end

endmodule
